// File: rtl/pacman_keycode_pkg.sv
// Shared definitions for the keycode input port.
// Holds the register addresses, the STATUS/DATA bit positions and a helper
// that clamps the FIFO count to the 4-bit STATUS count field.
package pacman_keycode_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA   = 2'd0,
        ADDR_STATUS = 2'd1,
        ADDR_CTRL   = 2'd2,
        ADDR_PEEK   = 2'd3
    } reg_addr_e;

    localparam int unsigned ST_EMPTY       = 8;
    localparam int unsigned ST_FULL        = 9;
    localparam int unsigned ST_OVF         = 10;
    localparam int unsigned DATA_VALID_BIT = 8;

    function automatic logic [3:0] sat_count(input int unsigned c);
        return (c > 15) ? 4'hF : 4'(c);
    endfunction

endpackage

// File: rtl/keycode_fifo.sv
// Small synchronous FIFO for keycodes.
// Ports: clk, reset_n (async active-low), push/din write side, pop read side,
// head (combinational view of the oldest entry), count, full, empty.
// A push and a pop in the same cycle are both honoured, including when full.
module keycode_fifo #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned KEY_W = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [KEY_W-1:0] din,
    output logic [KEY_W-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [KEY_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pacman_soc_keycode_in.sv
// Avalon-MM slave delivering hardware keycodes to the CPU through a FIFO.
// Ports: clk, reset_n (async active-low); Avalon address/chipselect/read_n/
// write_n/writedata/readdata (zero-wait reads); irq (level); in_keycode and
// in_valid push strobe from the keyboard side.
// Registers: 0 DATA (popping read), 1 STATUS (W1C overflow), 2 CTRL (irq_en),
// 3 PEEK (last accepted keycode).
// Optional macro KEYCODE_DEDUP_EN: drop pushes repeating the last accepted
// keycode, except keycode 0 (key release).
module pacman_soc_keycode_in
    import pacman_keycode_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned KEY_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [KEY_W-1:0] in_keycode,
    input  logic             in_valid
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             rd;
    logic             wr;
    logic             fifo_pop;
    logic             push_req;
    logic             push_ok;
    logic             dup;
    logic             ovf_set;
    logic             ovf_clr;
    logic             overflow;
    logic             irq_en;
    logic [KEY_W-1:0] last_key;
    logic [KEY_W-1:0] head;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             unused_ok;

    assign rd = chipselect & ~read_n;
    assign wr = chipselect & ~write_n;

    // An empty DATA read is harmless: it neither pops nor frees a slot.
    assign fifo_pop = rd & (address == ADDR_DATA) & ~empty;

`ifdef KEYCODE_DEDUP_EN
    assign dup = (in_keycode == last_key) && (in_keycode != '0);
`else
    assign dup = 1'b0;
`endif

    assign push_req = in_valid & ~dup;
    assign push_ok  = push_req & (~full | fifo_pop);
    assign ovf_set  = push_req & full & ~fifo_pop;
    assign ovf_clr  = wr & (address == ADDR_STATUS) & writedata[ST_OVF];

    keycode_fifo #(
        .DEPTH (DEPTH),
        .KEY_W (KEY_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_req),
        .pop     (fifo_pop),
        .din     (in_keycode),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            last_key <= '0;
        end else begin
            if (push_ok) last_key <= in_keycode;
            // A new overflow beats a simultaneous W1C clear.
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            if (wr && (address == ADDR_CTRL)) irq_en <= writedata[0];
        end
    end

    assign irq = irq_en & (~empty | overflow);

    always_comb begin
        readdata = '0;
        case (reg_addr_e'(address))
            ADDR_DATA: begin
                if (!empty) begin
                    readdata[KEY_W-1:0]     = head;
                    readdata[DATA_VALID_BIT] = 1'b1;
                end
            end
            ADDR_STATUS: begin
                readdata[3:0]      = sat_count(32'(count));
                readdata[ST_EMPTY] = empty;
                readdata[ST_FULL]  = full;
                readdata[ST_OVF]   = overflow;
            end
            ADDR_CTRL: readdata[0]         = irq_en;
            ADDR_PEEK: readdata[KEY_W-1:0] = last_key;
            default:   readdata            = '0;
        endcase
    end

    assign unused_ok = ^{writedata[31:11], writedata[9:1]};

endmodule

// File: tb/tb_pacman_soc_keycode_in.sv
module tb_pacman_soc_keycode_in;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned KEY_W = 8;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_PEEK   = 2'd3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       address = '0;
    logic             chipselect = 1'b0;
    logic             read_n = 1'b1;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;
    logic             irq;
    logic [KEY_W-1:0] in_keycode = '0;
    logic             in_valid = 1'b0;
    logic             irq_probe = 1'b0;

    typedef struct {
        string       name;
        logic [31:0] exp;
        bit          is_irq;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    pacman_soc_keycode_in #(
        .DEPTH (DEPTH),
        .KEY_W (KEY_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .in_keycode (in_keycode),
        .in_valid   (in_valid)
    );

    always #5 clk = ~clk;

    // Monitor: the DUT presents a response whenever a read is on the bus
    // (zero-wait) or the bench probes irq; each one pops the scoreboard.
    task automatic compare(input bit want_irq);
        exp_t        e;
        logic [31:0] act;
        act = want_irq ? {31'b0, irq} : readdata;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_response got=%h expected=<none>", act);
        end else begin
            e = sb.pop_front();
            if (e.is_irq != want_irq || act !== e.exp) begin
                bad++;
                $display("FAIL %s got=%h expected=%h", e.name, act, e.exp);
            end
        end
    endtask

    always @(negedge clk) begin
        if (chipselect && !read_n) compare(1'b0);
        if (irq_probe)             compare(1'b1);
    end

    // Drives one bus cycle starting just after a rising edge and returns
    // just after the edge that ends it, with the bus idled.
    task automatic cyc(input bit r, input bit w, input logic [1:0] a,
                       input logic [31:0] wd, input bit p,
                       input logic [KEY_W-1:0] k, input bit ip,
                       input logic [31:0] e, input string n);
        chipselect = r | w;
        read_n     = ~r;
        write_n    = ~w;
        address    = a;
        writedata  = wd;
        in_valid   = p;
        in_keycode = k;
        irq_probe  = ip;
        if (r)  sb.push_back('{n, e, 1'b0});
        if (ip) sb.push_back('{n, e, 1'b1});
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        in_valid   = 1'b0;
        irq_probe  = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string n);
        cyc(1'b1, 1'b0, a, '0, 1'b0, '0, 1'b0, e, n);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, a, d, 1'b0, '0, 1'b0, '0, "");
    endtask

    task automatic push(input logic [KEY_W-1:0] k);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, k, 1'b0, '0, "");
    endtask

    task automatic irqchk(input logic e, input string n);
        cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, {31'b0, e}, n);
    endtask

    initial begin
        // Reset state, checked while reset is held
        repeat (2) @(posedge clk);
        #1;
        rd(A_STATUS, 32'h100, "reset_status");
        reset_n = 1'b1;
        rd(A_CTRL,   32'h000, "reset_ctrl");
        rd(A_PEEK,   32'h000, "reset_peek");
        irqchk(1'b0, "reset_irq");

        // Basic push/pop and empty read
        push(8'h1A);
        push(8'h16);
        rd(A_DATA,   32'h11A, "pop_first");
        rd(A_DATA,   32'h116, "pop_second");
        rd(A_DATA,   32'h000, "pop_empty");
        rd(A_STATUS, 32'h100, "status_empty");
        rd(A_PEEK,   32'h016, "peek_last");

        // Overflow: nine pushes into eight entries
        for (int i = 0; i < 9; i++) push(8'(8'h21 + i));
        rd(A_STATUS, 32'h608, "status_full_ovf");
        rd(A_PEEK,   32'h028, "peek_not_dropped");
        // W1C clear coinciding with another overflow: set wins
        cyc(1'b0, 1'b1, A_STATUS, 32'h400, 1'b1, 8'h30, 1'b0, '0, "");
        rd(A_STATUS, 32'h608, "ovf_set_wins");
        wr(A_STATUS, 32'h400);
        rd(A_STATUS, 32'h208, "ovf_cleared");

        // Push and pop together while full
        cyc(1'b1, 1'b0, A_DATA, '0, 1'b1, 8'h2C, 1'b0, 32'h121, "full_pushpop_head");
        rd(A_STATUS, 32'h208, "full_pushpop_status");
        for (int i = 0; i < 7; i++) rd(A_DATA, 32'(32'h122 + i), "drain_order");
        rd(A_DATA,   32'h12C, "pushpop_key_last");
        rd(A_DATA,   32'h000, "ninth_absent");

        // Push into an empty FIFO while reading DATA: read sees empty
        cyc(1'b1, 1'b0, A_DATA, '0, 1'b1, 8'h33, 1'b0, 32'h000, "empty_pushpop_read");
        rd(A_DATA,   32'h133, "empty_pushpop_kept");

        // Interrupt
        wr(A_CTRL, 32'h1);
        rd(A_CTRL, 32'h1, "ctrl_readback");
        irqchk(1'b0, "irq_en_empty");
        push(8'h04);
        irqchk(1'b1, "irq_pending");
        rd(A_DATA, 32'h104, "irq_pop");
        irqchk(1'b0, "irq_after_pop");
        for (int i = 0; i < 9; i++) push(8'(8'h41 + i));
        rd(A_STATUS, 32'h608, "irq_fill_status");
        for (int i = 0; i < 8; i++) rd(A_DATA, 32'(32'h141 + i), "irq_drain");
        irqchk(1'b1, "irq_ovf_only");
        wr(A_CTRL, 32'h0);
        irqchk(1'b0, "irq_disabled_ovf");
        wr(A_STATUS, 32'h400);
        rd(A_STATUS, 32'h100, "irq_ovf_cleared");

        // Repeated keycodes
        push(8'h04);
        push(8'h04);
        push(8'h00);
        push(8'h04);
`ifdef KEYCODE_DEDUP_EN
        rd(A_DATA, 32'h104, "dedup_0");
        rd(A_DATA, 32'h100, "dedup_1");
        rd(A_DATA, 32'h104, "dedup_2");
`else
        rd(A_DATA, 32'h104, "nodedup_0");
        rd(A_DATA, 32'h104, "nodedup_1");
        rd(A_DATA, 32'h100, "nodedup_2");
        rd(A_DATA, 32'h104, "nodedup_3");
`endif
        rd(A_DATA, 32'h000, "dup_drained");
        rd(A_PEEK, 32'h004, "dup_peek");

        // Reset in the middle of activity
        for (int i = 0; i < 5; i++) push(8'(8'h51 + i));
        rd(A_STATUS, 32'h005, "pre_reset_count");
        wr(A_CTRL, 32'h1);
        irqchk(1'b1, "pre_reset_irq");
        fork
            begin
                #2 reset_n = 1'b0;
            end
        join_none
        rd(A_DATA,   32'h000, "reset_mid_data");
        rd(A_STATUS, 32'h100, "reset_mid_status");
        irqchk(1'b0, "reset_mid_irq");
        rd(A_PEEK,   32'h000, "reset_mid_peek");
        reset_n = 1'b1;
        rd(A_CTRL,   32'h000, "post_reset_ctrl");
        rd(A_DATA,   32'h000, "post_reset_data");

        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
